// File: rtl/tickgen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tickgen_pkg;

  typedef enum logic [1:0] {
    TM_OFF      = 2'b00,
    TM_PERIODIC = 2'b01,
    TM_ONESHOT  = 2'b10,
    TM_RSVD     = 2'b11
  } tick_mode_t;

  typedef enum logic {
    TS_IDLE = 1'b0,
    TS_RUN  = 1'b1
  } tick_state_t;

  // Channel index width; a single-channel build still gets a 1-bit index.
  function automatic int tickgen_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tickgen_channel.sv
// One tick generator channel: IDLE/RUN FSM, enabled counter, shadow and
// active period registers, optional square-wave toggle.
// Optional feature macro: TICKGEN_TOGGLE_EN (div_out toggles on every tick).
module tickgen_channel
  import tickgen_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              wr,
  input  logic [1:0]        wr_mode,
  input  logic [DWIDTH-1:0] wr_max,
  input  logic              wr_now,
  output logic              tick,
  output logic              busy,
  output logic              div_out
);

  tick_state_t       state;
  tick_mode_t        mode;
  tick_mode_t        wr_m;
  logic [DWIDTH-1:0] count;
  logic [DWIDTH-1:0] act_max;
  logic [DWIDTH-1:0] shd_max;
  logic              tick_r;
  logic              running;
  logic              term;
  logic              fire;
  logic              wr_off;

  assign wr_m    = tick_mode_t'(wr_mode);
  assign running = (state == TS_RUN);
  // Terminal count only advances on enabled RUN cycles.
  assign term    = running && en && (count == act_max);
  // An immediate period change restarts the count and swallows that cycle's tick.
  assign fire    = term && !(wr && wr_now);
  // Reserved mode behaves exactly like OFF.
  assign wr_off  = wr && ((wr_m == TM_OFF) || (wr_m == TM_RSVD));

  assign tick = tick_r;
  assign busy = running;

  // Counter, period registers, tick pulse and mode/state FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TS_IDLE;
      mode    <= TM_OFF;
      count   <= '0;
      act_max <= '0;
      shd_max <= '0;
      tick_r  <= 1'b0;
    end else begin
      tick_r <= fire;

      if (wr && (wr_now || wr_off)) begin
        count <= '0;
      end else if (term) begin
        count <= '0;
      end else if (running && en) begin
        count <= count + 1'b1;
      end

      // New period waits in the shadow until the running period completes.
      if (wr) begin
        shd_max <= wr_max;
        if (wr_now || !running) begin
          act_max <= wr_max;
        end else if (fire) begin
          act_max <= shd_max;
        end
      end else if (fire) begin
        act_max <= shd_max;
      end

      if (wr) begin
        mode <= wr_off ? TM_OFF : wr_m;
        if (wr_off) begin
          state <= TS_IDLE;
        end else if (wr_m == TM_PERIODIC) begin
          state <= TS_RUN;
        end else if (fire && (mode == TM_ONESHOT)) begin
          state <= TS_IDLE;
        end
      end else begin
        case (state)
          TS_IDLE: begin
            if ((mode == TM_PERIODIC) || ((mode == TM_ONESHOT) && start)) begin
              state <= TS_RUN;
            end
          end
          TS_RUN: begin
            if (fire && (mode == TM_ONESHOT)) begin
              state <= TS_IDLE;
            end
          end
          default: state <= TS_IDLE;
        endcase
      end
    end
  end

`ifdef TICKGEN_TOGGLE_EN
  logic div_r;

  // Square wave: flips on every tick, forced low when the channel is switched off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= 1'b0;
    end else if (wr_off) begin
      div_r <= 1'b0;
    end else if (fire) begin
      div_r <= ~div_r;
    end
  end

  assign div_out = div_r;
`else
  assign div_out = 1'b0;
`endif

endmodule

// File: rtl/tickgen_multi.sv
// Multi-channel runtime-programmable tick generator: config address decode,
// write steering to NCH channel instances, and invalid-address error pulse.
// Optional feature macro: TICKGEN_TOGGLE_EN (square-wave div_out per channel).
module tickgen_multi
  import tickgen_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DWIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              en,
  input  logic [NCH-1:0]              start,
  input  logic                        cfg_we,
  input  logic [tickgen_chw(NCH)-1:0] cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [DWIDTH-1:0]           cfg_max,
  input  logic                        cfg_now,
  output logic [NCH-1:0]              tick,
  output logic [NCH-1:0]              busy,
  output logic                        cfg_err,
  output logic [NCH-1:0]              div_out
);

  localparam int CHW = tickgen_chw(NCH);

  logic           ch_bad;
  logic [NCH-1:0] wr;

  // Addresses past the last channel are dropped and flagged.
  assign ch_bad = (32'(cfg_ch) >= NCH);

  // Registered one-cycle error pulse for writes to a non-existent channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ch_bad;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_we && (cfg_ch == CHW'(i));

    tickgen_channel #(
      .DWIDTH (DWIDTH)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .start   (start[i]),
      .wr      (wr[i]),
      .wr_mode (cfg_mode),
      .wr_max  (cfg_max),
      .wr_now  (cfg_now),
      .tick    (tick[i]),
      .busy    (busy[i]),
      .div_out (div_out[i])
    );
  end

endmodule

// File: tb/tb_tickgen_multi.sv
// Scoreboard bench for tickgen_multi: stimulus pushes expected tick events
// (cycle, channel); a negedge monitor pops and compares every observed tick.
module tb_tickgen_multi;

  localparam int NCH    = 3;
  localparam int DWIDTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    en = '1;
  logic [NCH-1:0]    start = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [DWIDTH-1:0] cfg_max = '0;
  logic              cfg_now = 1'b0;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    busy;
  logic              cfg_err;
  logic [NCH-1:0]    div_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int q[$];

  tickgen_multi #(.NCH(NCH), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_max(cfg_max), .cfg_now(cfg_now),
    .tick(tick), .busy(busy), .cfg_err(cfg_err), .div_out(div_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick seen must match the next expected (cycle, channel).
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (tick[c]) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL tick_unexpected: got tick ch=%0d cyc=%0d, required none", c, cyc);
        end else begin
          int e;
          e = q.pop_front();
          if (e != cyc * 16 + c) begin
            fails++;
            $display("FAIL tick_event: got ch=%0d cyc=%0d, required ch=%0d cyc=%0d",
                     c, cyc, e % 16, e / 16);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input int ch);
    q.push_back(c * 16 + ch);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  // Config write sampled at the next rising edge; p returns that edge's index.
  task automatic cfg(input int ch, input logic [1:0] mode, input int mx,
                     input logic now, output int p);
    cfg_ch   = 2'(ch);
    cfg_mode = mode;
    cfg_max  = DWIDTH'(mx);
    cfg_now  = now;
    cfg_we   = 1'b1;
    step();
    cfg_we   = 1'b0;
    cfg_now  = 1'b0;
    p = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, s, d, bcnt;

    // Reset state
    step();
    step();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_div", 32'(div_out), 0);
    reset = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy), 0);

    // 1: PERIODIC max=3 on ch0
    cfg(0, 2'b01, 3, 1'b0, p);
    push(p + 4, 0); push(p + 8, 0); push(p + 12, 0); push(p + 16, 0);
    step();
    chk("t1_busy_run", 32'(busy[0]), 1);
    wait_to(p + 17);
    cfg(0, 2'b00, 3, 1'b0, d);
    chk("t1_busy_off", 32'(busy[0]), 0);

    // 2: en low two cycles mid-period on ch1
    cfg(1, 2'b01, 3, 1'b0, p);
    push(p + 4, 1); push(p + 8, 1); push(p + 14, 1); push(p + 18, 1);
    wait_to(p + 9);
    en[1] = 1'b0;
    step();
    step();
    en[1] = 1'b1;
    wait_to(p + 19);
    cfg(1, 2'b00, 3, 1'b0, d);

    // 3: ONESHOT max=5 on ch2, retrigger during RUN ignored
    cfg(2, 2'b10, 5, 1'b0, p);
    chk("t3_idle_armed", 32'(busy[2]), 0);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    s = cyc;
    push(s + 6, 2);
    bcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy[2]) bcnt++;
      start[2] = (k == 2);
      step();
    end
    start[2] = 1'b0;
    chk("t3_busy_cycles", 32'(bcnt), 6);
    chk("t3_idle_after", 32'(busy[2]), 0);
    // start coincident with a mode write to the same channel is ignored
    start[2] = 1'b1;
    cfg(2, 2'b10, 5, 1'b0, d);
    start[2] = 1'b0;
    chk("t3_start_vs_wr", 32'(busy[2]), 0);
    step();
    chk("t3_start_vs_wr2", 32'(busy[2]), 0);
    cfg(2, 2'b00, 0, 1'b0, d);

    // 4: shadow period update vs immediate update on ch0
    cfg(0, 2'b01, 7, 1'b0, p);
    push(p + 8, 0);  push(p + 16, 0); push(p + 24, 0); push(p + 26, 0);
    push(p + 28, 0); push(p + 30, 0); push(p + 32, 0); push(p + 40, 0);
    push(p + 48, 0); push(p + 53, 0); push(p + 55, 0); push(p + 57, 0);
    wait_to(p + 17);
    cfg(0, 2'b01, 1, 1'b0, d);
    wait_to(p + 30);
    cfg(0, 2'b01, 7, 1'b0, d);
    wait_to(p + 50);
    cfg(0, 2'b01, 1, 1'b1, d);
    wait_to(p + 57);
    cfg(0, 2'b00, 0, 1'b0, d);

    // 5: max=0 ticks every cycle; invalid channel write flags cfg_err only
    cfg(1, 2'b01, 0, 1'b0, p);
    for (int k = 1; k <= 7; k++) push(p + k, 1);
    wait_to(p + 3);
    cfg(3, 2'b00, 5, 1'b0, d);
    chk("t5_err_pulse", 32'(cfg_err), 1);
    chk("t5_ch1_unchanged", 32'(busy[1]), 1);
    step();
    chk("t5_err_clear", 32'(cfg_err), 0);
    wait_to(p + 6);
    cfg(1, 2'b00, 0, 1'b0, d);
    chk("t5_off", 32'(busy[1]), 0);

    // 6: div_out square wave on ch2 with max=2
    cfg(2, 2'b01, 2, 1'b0, p);
    push(p + 3, 2); push(p + 6, 2); push(p + 9, 2); push(p + 12, 2);
`ifdef TICKGEN_TOGGLE_EN
    wait_to(p + 3);  chk("t6_div_a", 32'(div_out[2]), 1);
    wait_to(p + 5);  chk("t6_div_b", 32'(div_out[2]), 1);
    wait_to(p + 6);  chk("t6_div_c", 32'(div_out[2]), 0);
    wait_to(p + 9);  chk("t6_div_d", 32'(div_out[2]), 1);
`else
    wait_to(p + 3);  chk("t6_div_a", 32'(div_out[2]), 0);
    wait_to(p + 5);  chk("t6_div_b", 32'(div_out[2]), 0);
    wait_to(p + 6);  chk("t6_div_c", 32'(div_out[2]), 0);
    wait_to(p + 9);  chk("t6_div_d", 32'(div_out[2]), 0);
`endif
    wait_to(p + 12);
    cfg(2, 2'b00, 0, 1'b0, d);
    chk("t6_div_off", 32'(div_out[2]), 0);

    // 7: asynchronous reset mid-count, no tick after release
    cfg(0, 2'b01, 3, 1'b0, p);
    push(p + 4, 0);
    wait_to(p + 6);
    chk("t7_busy_pre", 32'(busy[0]), 1);
    reset = 1'b0;
    #1;
    chk("t7_busy_async", 32'(busy), 0);
    chk("t7_tick_async", 32'(tick), 0);
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("t7_busy_after", 32'(busy), 0);
    chk("t7_div_after", 32'(div_out), 0);

    step();
    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
